// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory port of the fetch stage: address/strobe out, asynchronous read data back.
interface instruction_fetch_unit_if;
  logic [15:0] IF_imemAddr;
  logic        IF_imemRead;
  logic [15:0] IF_imemData;

  modport master (output IF_imemAddr, output IF_imemRead, input IF_imemData);
  modport slave  (input IF_imemAddr, input IF_imemRead, output IF_imemData);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, IF/ID pipeline register, and saturating fetch/bubble counters.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IF_stall,
  input  logic                       IF_branchTaken,
  input  logic [15:0]                IF_branchTarget,
  input  logic                       IF_memConflict,
  instruction_fetch_unit_if.master   imem,
  output logic [15:0]                IF_instruction,
  output logic [15:0]                IF_pcPlus1,
  output logic                       IF_valid,
  output logic [15:0]                IF_fetchCount,
  output logic [15:0]                IF_bubbleCount
);

  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc_plus1;
  logic        r_valid;
  logic [15:0] r_fetch_count;
  logic [15:0] r_bubble_count;

  logic [15:0] w_pc_next;
  logic [15:0] w_instr_next;
  logic [15:0] w_pc_plus1_next;
  logic        w_valid_next;
  logic [15:0] w_fetch_count_next;
  logic [15:0] w_bubble_count_next;
  logic [15:0] w_fetch_inc;
  logic [15:0] w_bubble_inc;

  assign w_fetch_inc  = (r_fetch_count  == 16'hFFFF) ? r_fetch_count  : r_fetch_count  + 16'd1;
  assign w_bubble_inc = (r_bubble_count == 16'hFFFF) ? r_bubble_count : r_bubble_count + 16'd1;

  // Stall outranks redirect and conflict; a redirect absorbs a simultaneous conflict.
  always_comb begin
    w_pc_next           = r_pc;
    w_instr_next        = r_instr;
    w_pc_plus1_next     = r_pc_plus1;
    w_valid_next        = r_valid;
    w_fetch_count_next  = r_fetch_count;
    w_bubble_count_next = r_bubble_count;
    if (IF_stall) begin
      w_pc_next = r_pc;
    end else if (IF_branchTaken) begin
      w_pc_next           = IF_branchTarget;
      w_instr_next        = NOP_INSTR;
      w_pc_plus1_next     = 16'h0000;
      w_valid_next        = 1'b0;
      w_bubble_count_next = w_bubble_inc;
    end else if (IF_memConflict) begin
      w_instr_next        = NOP_INSTR;
      w_pc_plus1_next     = 16'h0000;
      w_valid_next        = 1'b0;
      w_bubble_count_next = w_bubble_inc;
    end else begin
      w_pc_next          = r_pc + 16'd1;
      w_instr_next       = imem.IF_imemData;
      w_pc_plus1_next    = r_pc + 16'd1;
      w_valid_next       = 1'b1;
      w_fetch_count_next = w_fetch_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc           <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_pc_plus1     <= 16'h0000;
      r_valid        <= 1'b0;
      r_fetch_count  <= 16'h0000;
      r_bubble_count <= 16'h0000;
    end else begin
      r_pc           <= w_pc_next;
      r_instr        <= w_instr_next;
      r_pc_plus1     <= w_pc_plus1_next;
      r_valid        <= w_valid_next;
      r_fetch_count  <= w_fetch_count_next;
      r_bubble_count <= w_bubble_count_next;
    end
  end

  assign imem.IF_imemAddr = r_pc;
  assign imem.IF_imemRead = rst & ~IF_stall & ~IF_memConflict & ~IF_branchTaken;
  assign IF_instruction   = r_instr;
  assign IF_pcPlus1       = r_pc_plus1;
  assign IF_valid         = r_valid;
  assign IF_fetchCount    = r_fetch_count;
  assign IF_bubbleCount   = r_bubble_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized checks of the fetch stage against a cycle-level reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [15:0] tgt;
  logic        conf;
  logic [15:0] instr;
  logic [15:0] pcp1;
  logic        valid;
  logic [15:0] fcnt;
  logic [15:0] bcnt;

  int tests  = 0;
  int failed = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_pcp1;
  logic        m_valid;
  int          m_fc, m_bc;

  instruction_fetch_unit_if bus ();
  assign bus.IF_imemData = bus.IF_imemAddr ^ 16'hA5A5;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .IF_stall        (stall),
    .IF_branchTaken  (br),
    .IF_branchTarget (tgt),
    .IF_memConflict  (conf),
    .imem            (bus.master),
    .IF_instruction  (instr),
    .IF_pcPlus1      (pcp1),
    .IF_valid        (valid),
    .IF_fetchCount   (fcnt),
    .IF_bubbleCount  (bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic b, input logic c,
                            input logic [15:0] t);
    if (!r) begin
      m_pc = 16'h0000; m_instr = 16'h0800; m_pcp1 = 16'h0000; m_valid = 1'b0;
      m_fc = 0; m_bc = 0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (b || c) begin
      if (b) m_pc = t;
      m_instr = 16'h0800; m_pcp1 = 16'h0000; m_valid = 1'b0;
      m_bc = sat_inc(m_bc);
    end else begin
      m_instr = m_pc ^ 16'hA5A5;
      m_pcp1  = m_pc + 16'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
      m_fc    = sat_inc(m_fc);
    end
  endtask

  task automatic chk_all();
    chk("imemAddr", bus.IF_imemAddr, m_pc);
    chk("instruction", instr, m_instr);
    chk("pcPlus1", pcp1, m_pcp1);
    chk("valid", {15'd0, valid}, {15'd0, m_valid});
    chk("fetchCount", fcnt, m_fc[15:0]);
    chk("bubbleCount", bcnt, m_bc[15:0]);
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic c,
                      input logic [15:0] t);
    rst = r; stall = s; br = b; conf = c; tgt = t;
    #1;
    chk("imemRead", {15'd0, bus.IF_imemRead}, {15'd0, r & ~s & ~c & ~b});
    @(posedge clk);
    model_edge(r, s, b, c, t);
    #1;
    chk_all();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br = 1'b0; conf = 1'b0; tgt = 16'h0000;
    m_pc = 16'h0000; m_instr = 16'h0800; m_pcp1 = 16'h0000; m_valid = 1'b0;
    m_fc = 0; m_bc = 0;

    // reset then free run
    step(0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 16'h0000);
    chk("rst_instr", instr, 16'h0800);
    step(1, 0, 0, 0, 16'h0000);
    chk("run_instr0", instr, 16'hA5A5);
    step(1, 0, 0, 0, 16'h0000);
    chk("run_instr1", instr, 16'hA5A4);
    step(1, 0, 0, 0, 16'h0000);
    chk("run_instr2", instr, 16'hA5A7);
    chk("run_pcp1_2", pcp1, 16'h0003);
    chk("run_fcnt3", fcnt, 16'h0003);

    // load-use stall with a simultaneous branch at PC=5
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("pre_stall_pc", bus.IF_imemAddr, 16'h0005);
    step(1, 1, 1, 0, 16'h0123);
    step(1, 1, 1, 0, 16'h0123);
    chk("stall_pc", bus.IF_imemAddr, 16'h0005);
    chk("stall_pcp1", pcp1, 16'h0005);
    chk("stall_bcnt", bcnt, 16'h0000);

    // taken branch at PC=8
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("pre_br_pc", bus.IF_imemAddr, 16'h0008);
    step(1, 0, 1, 0, 16'h0040);
    chk("br_instr", instr, 16'h0800);
    chk("br_addr", bus.IF_imemAddr, 16'h0040);
    chk("br_bcnt", bcnt, 16'h0001);
    step(1, 0, 0, 0, 16'h0000);
    chk("br_pcp1", pcp1, 16'h0041);

    // structural conflict at PC=0x10
    step(1, 0, 1, 0, 16'h0010);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 16'h0000);
    chk("conf_pc", bus.IF_imemAddr, 16'h0010);
    chk("conf_bcnt", bcnt, 16'h0005);
    step(1, 0, 0, 0, 16'h0000);
    chk("conf_resume", pcp1, 16'h0011);

    // conflict plus branch, then PC wrap
    step(1, 0, 1, 1, 16'hFFFF);
    chk("cb_pc", bus.IF_imemAddr, 16'hFFFF);
    step(1, 0, 0, 0, 16'h0000);
    chk("wrap_pcp1", pcp1, 16'h0000);
    chk("wrap_pc", bus.IF_imemAddr, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);

    // counter saturation
    force dut.r_fetch_count = 16'hFFFE;
    force dut.r_bubble_count = 16'hFFFE;
    #1;
    release dut.r_fetch_count;
    release dut.r_bubble_count;
    m_fc = 32'h0000_FFFE; m_bc = 32'h0000_FFFE;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'h0000);
    chk("sat_fcnt", fcnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 16'h0000);
    chk("sat_bcnt", bcnt, 16'hFFFF);

    // reset mid-stall
    step(1, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 1, 16'h1234);
    chk("midrst_addr", bus.IF_imemAddr, 16'h0000);
    chk("midrst_fcnt", fcnt, 16'h0000);
    chk("midrst_bcnt", bcnt, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
